// File: rtl/vram_text_scanner.sv
// Text-mode scan-out: raster counters, VRAM/font fetch pipeline, pixel serialiser.
// Optional blinking cursor inversion enabled by VRAM_SCANNER_CURSOR_EN.
module vram_text_scanner #(
  parameter int COLS        = 40,
  parameter int ROWS        = 25,
  parameter int CHAR_H      = 8,
  parameter int H_TOTAL     = 400,
  parameter int V_TOTAL     = 262,
  parameter int HSYNC_START = 344,
  parameter int HSYNC_LEN   = 32,
  parameter int VSYNC_START = 230,
  parameter int VSYNC_LEN   = 3,
  parameter int ADDR_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic [7:0]            vram_q,
  output logic [10:0]           font_addr,
  input  logic [7:0]            font_q,
  output logic                  pixel,
  output logic                  active,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
`ifdef VRAM_SCANNER_CURSOR_EN
  ,
  input  logic [ADDR_WIDTH-1:0] cursor_pos,
  input  logic                  cursor_on
`endif
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int GS    = $clog2(CHAR_H);
  localparam int ACT_V = ROWS * CHAR_H;
  localparam int X1    = 8 + 8 * COLS;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [31:0]           h32;
  logic [31:0]           v32;
  logic [31:0]           text_row;
  logic [2:0]            glyph_row;
  logic [2:0]            phase;
  logic [ADDR_WIDTH-1:0] cell_addr;
  logic                  h_last;
  logic                  v_last;
  logic                  fetch;
  logic                  disp;
  logic                  hs;
  logic                  vs;
  logic                  top;
  logic [7:0]            glyph;
  logic [7:0]            glyph_in;
  logic [7:0]            shifter;

  always_comb begin
    h32       = 32'(h_cnt);
    v32       = 32'(v_cnt);
    text_row  = v32 >> GS;
    glyph_row = 3'(v32 & 32'(CHAR_H - 1));
    phase     = h_cnt[2:0];
    cell_addr = ADDR_WIDTH'(text_row * 32'(COLS) + (h32 >> 3));
    h_last    = h32 == 32'(H_TOTAL - 1);
    v_last    = v32 == 32'(V_TOTAL - 1);
    fetch     = (v32 < 32'(ACT_V)) && (h32 < 32'(8 * COLS));
    disp      = (v32 < 32'(ACT_V)) && (h32 >= 32'd8) && (h32 < 32'(X1));
    hs        = (h32 >= 32'(HSYNC_START))
             && (h32 < 32'(HSYNC_START + HSYNC_LEN));
    vs        = (v32 >= 32'(VSYNC_START))
             && (v32 < 32'(VSYNC_START + VSYNC_LEN));
    top       = (h_cnt == '0) && (v_cnt == '0);
  end

`ifdef VRAM_SCANNER_CURSOR_EN
  logic [4:0] frame_cnt;
  logic       cur_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      cur_hit   <= 1'b0;
    end else if (pix_en) begin
      if (top) frame_cnt <= frame_cnt + 5'd1;
      if (fetch && phase == 3'd0)
        cur_hit <= cursor_on && frame_cnt[4]
                && (cell_addr == cursor_pos);
    end
  end

  assign glyph_in = font_q ^ {8{cur_hit}};
`else
  assign glyph_in = font_q;
`endif

  // Counters hold the position of the tick being issued; outputs reflect it.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vram_addr   <= '0;
      font_addr   <= '0;
      glyph       <= '0;
      shifter     <= '0;
      pixel       <= 1'b0;
      active      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      active      <= disp;
      hsync       <= hs;
      vsync       <= vs;
      frame_start <= top;
      if (fetch && phase == 3'd0) vram_addr <= cell_addr;
      if (fetch && phase == 3'd2) font_addr <= {vram_q, glyph_row};
      if (fetch && phase == 3'd4) glyph <= glyph_in;
      if (disp && phase == 3'd0) begin
        pixel   <= glyph[7];
        shifter <= {glyph[6:0], 1'b0};
      end else begin
        pixel   <= disp & shifter[7];
        shifter <= {shifter[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_vram_text_scanner.sv
// Scoreboard bench for vram_text_scanner on a reduced raster geometry.
// Behavioural VRAM and font ROM, each with one clock of read latency.
module tb_vram_text_scanner;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int CH   = 8;
  localparam int HT   = 58;
  localparam int VT   = 20;
  localparam int HSS  = 44;
  localparam int HSL  = 6;
  localparam int VSS  = 17;
  localparam int VSL  = 2;
  localparam int AW   = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_en = 1'b0;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_q = 8'h00;
  logic [10:0]   font_addr;
  logic [7:0]    font_q = 8'h00;
  logic          pixel;
  logic          active;
  logic          hsync;
  logic          vsync;
  logic          frame_start;

  vram_text_scanner #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H(CH),
    .H_TOTAL(HT), .V_TOTAL(VT),
    .HSYNC_START(HSS), .HSYNC_LEN(HSL),
    .VSYNC_START(VSS), .VSYNC_LEN(VSL),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vram_addr(vram_addr), .vram_q(vram_q),
    .font_addr(font_addr), .font_q(font_q),
    .pixel(pixel), .active(active),
    .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];

  function automatic logic [7:0] font_fn(input logic [10:0] a);
    logic [7:0] r;
    if (a == 11'h208) r = 8'hA5;
    else r = (a[10:3] * 8'd3) ^ {a[2:0], a[2:0], 2'b01};
    return r;
  endfunction

  always @(posedge clk) begin
    vram_q <= mem[vram_addr];
    font_q <= font_fn(font_addr);
  end

  typedef struct {
    int          h;
    int          v;
    logic        pixel;
    logic        active;
    logic        hsync;
    logic        vsync;
    logic        fs;
    logic [AW-1:0] va;
    logic [10:0] fa;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  int          mh;
  int          mv;
  logic [AW-1:0] ea;
  logic [10:0] ef;

  task automatic check(input string name, input int h, input int v,
                       input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s at h=%0d v=%0d: got %0h want %0h",
                 name, h, v, got, want);
    end
  endtask

  task automatic issue();
    exp_t e;
    int c;
    int b;
    logic [7:0] g;
    e.h = mh;
    e.v = mv;
    e.active = (mh >= 8) && (mh < 8 + 8 * COLS) && (mv < ROWS * CH);
    e.pixel = 1'b0;
    if (e.active) begin
      c = (mh - 8) / 8;
      b = 7 - ((mh - 8) % 8);
      g = font_fn({mem[(mv / CH) * COLS + c], 3'(mv % CH)});
      e.pixel = g[b];
    end
    if (mv < ROWS * CH && mh < 8 * COLS) begin
      if (mh % 8 == 0) ea = AW'((mv / CH) * COLS + mh / 8);
      if (mh % 8 == 2) ef = {mem[ea], 3'(mv % CH)};
    end
    e.va = ea;
    e.fa = ef;
    e.hsync = (mh >= HSS) && (mh < HSS + HSL);
    e.vsync = (mv >= VSS) && (mv < VSS + VSL);
    e.fs = (mh == 0) && (mv == 0);
    sb.push_back(e);
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic tick_clk(input bit en);
    @(negedge clk);
    pix_en = en;
    if (en) issue();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pixel", -1, -1, 32'(pixel), 0);
    check("reset_active", -1, -1, 32'(active), 0);
    check("reset_hsync", -1, -1, 32'(hsync), 0);
    check("reset_vsync", -1, -1, 32'(vsync), 0);
    check("reset_fs", -1, -1, 32'(frame_start), 0);
    check("reset_vaddr", -1, -1, 32'(vram_addr), 0);
    check("reset_faddr", -1, -1, 32'(font_addr), 0);
    reset = 1'b0;
    pix_en = 1'b0;
    mh = 0;
    mv = 0;
    ea = '0;
    ef = '0;
  endtask

  logic mon_en;
  exp_t mon_e;

  always @(posedge clk) begin
    mon_en = pix_en && !reset;
    #1;
    if (mon_en) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_empty: got tick with no expectation want none");
      end else begin
        mon_e = sb.pop_front();
        check("pixel", mon_e.h, mon_e.v, 32'(pixel), 32'(mon_e.pixel));
        check("active", mon_e.h, mon_e.v, 32'(active), 32'(mon_e.active));
        check("hsync", mon_e.h, mon_e.v, 32'(hsync), 32'(mon_e.hsync));
        check("vsync", mon_e.h, mon_e.v, 32'(vsync), 32'(mon_e.vsync));
        check("frame_start", mon_e.h, mon_e.v,
              32'(frame_start), 32'(mon_e.fs));
        check("vram_addr", mon_e.h, mon_e.v, 32'(vram_addr), 32'(mon_e.va));
        check("font_addr", mon_e.h, mon_e.v, 32'(font_addr), 32'(mon_e.fa));
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h41;
    mh = 0;
    mv = 0;
    ea = '0;
    ef = '0;
    apply_reset();
    // Every-clock strobe, stopping mid-line inside hsync of frame 2.
    repeat (HT * VT + 9 * HT + 47) tick_clk(1'b1);
    apply_reset();
    // Strobe every third clock.
    repeat (2 * HT * VT + 10) begin
      tick_clk(1'b1);
      tick_clk(1'b0);
      tick_clk(1'b0);
    end
    // Irregular gaps.
    repeat (400) begin
      tick_clk(1'b1);
      repeat ($urandom_range(0, 2)) tick_clk(1'b0);
    end
    @(negedge clk);
    pix_en = 1'b0;
    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
